bist_engine: RTL and testbench
==============================

Name: bist_engine

Overview:
Parametrised, self-contained BIST engine. It is the successor to the fixed 4-request/8-bit-MISR BIST wrapper.
- Drives an external circuit-under-test (CUT) with LFSR patterns through a functional/test mux.
- Exercises the CUT's scan chain in and out.
- Compacts parallel responses and scan-out into a MISR of configurable width.
- Flags pass/fail against a reference signature.
- Instantiated beside the CUT in each BIST-enabled top.

Parameters:
PAT_BITS, 4, width of pattern bus / CUT functional inputs (≥2)
RESP_BITS, 4, width of CUT parallel response bus (RESP_BITS+1 ≤ MISR_BITS)
MISR_BITS, 16, signature width
LFSR_TAPS, 4'b1100, LFSR feedback tap mask (PAT_BITS wide)
LFSR_SEED, 4'b0001, LFSR start value; all-zero is coerced to 1
MISR_TAPS, 16'hB400, MISR feedback tap mask
SCAN_LEN, 8, CUT scan-chain length in cycles (≥1)
PAT_COUNT, 255, functional pattern cycles per run (≥1)
SIGNATURE_VALID, 16'h0000, golden signature

Ports:
clock  in  1  single clock
reset  in  1  synchronous, active-high; one clock, synchronous active-high reset
bist_start  in  1  level-sampled start request
func_in  in  PAT_BITS  mission-mode CUT inputs
pat_o  out  PAT_BITS  muxed CUT inputs
cut_reset_o  out  1  CUT reset: reset OR engine INIT
scan_en_o  out  1  CUT scan enable
scan_in_o  out  1  CUT scan input
scan_out_i  in  1  CUT scan output
resp_i  in  RESP_BITS  CUT parallel response
bist_busy  out  1  engine active (INIT..SHIFT_OUT)
bist_end  out  1  run complete, held
pass_fail  out  1  bist_end AND signature_o == SIGNATURE_VALID
signature_o  out  MISR_BITS  MISR contents

Behaviour:
- Reset: FSM=IDLE; LFSR=seed; MISR=0; counter=0.
  - Outputs: bist_busy=0, bist_end=0, pass_fail=0, scan_en_o=0, cut_reset_o=1, signature_o=0.
- FSM states:
  - IDLE: on bist_start=1, go to INIT.
  - INIT: 1 cycle. cut_reset_o=1; LFSR←seed; MISR←0. Then go to SHIFT_IN.
  - SHIFT_IN: SCAN_LEN cycles, scan_en_o=1. Then go to RUN.
  - RUN: PAT_COUNT cycles, scan_en_o=0. Then go to SHIFT_OUT.
  - SHIFT_OUT: SCAN_LEN cycles, scan_en_o=1. Then go to DONE.
  - DONE: bist_end=1, held. bist_start=1 restarts at INIT; otherwise stay.
- Timing: bist_start sampled at edge k → DONE first visible after edge k+2+2·SCAN_LEN+PAT_COUNT.
- bist_start is ignored while bist_busy=1.
- Reset mid-run returns to IDLE with all reset values.
- LFSR (Fibonacci):
  - fb = ^(L & LFSR_TAPS); L ← {L[PAT_BITS-2:0], fb}.
  - Advances every cycle in SHIFT_IN, RUN and SHIFT_OUT; holds otherwise.
  - scan_in_o = L[PAT_BITS-1].
- pat_o = L when bist_busy, else func_in.
- MISR:
  - v = zero-extended {scan_out_i, resp_i} to MISR_BITS.
  - fb = ^(M & MISR_TAPS); M ← {M[MISR_BITS-2:0], fb} ^ v.
  - Updates in SHIFT_IN, RUN and SHIFT_OUT only; holds in IDLE and DONE.
- signature_o = M at all times. pass_fail is combinational from registered values.
- Counter: width $clog2(max(SCAN_LEN,PAT_COUNT)+1). Loads 0 on each state entry; the terminal compare is count == N-1.

Optional Feature:
- BIST_ABORT_EN defined:
  - Adds input bist_abort (1 bit).
  - bist_abort=1 in any busy state → IDLE next edge: bist_end=0, MISR cleared, LFSR←seed, cut_reset_o=1.
  - In IDLE/DONE, bist_abort is ignored.
  - Abort takes priority over state-completion transitions.
- BIST_ABORT_EN undefined: port absent; runs always complete.

Decomposition:
- Package bist_pkg:
  - state enum (IDLE, INIT, SHIFT_IN, RUN, SHIFT_OUT, DONE);
  - function lfsr_next(state, taps);
  - default tap constants for 4/8/16/32 bits.
- One sub-module, bist_misr (MISR_BITS, MISR_TAPS; clock, reset, clear, enable, v, signature), instantiated once.
- FSM, counter and LFSR stay in bist_engine.

Test Plan:
1. Reset asserted 3 cycles with bist_start=1 → bist_busy=0, bist_end=0, signature_o=0, cut_reset_o=1, scan_en_o=0.
2. SCAN_LEN=2, PAT_COUNT=4, start pulse at edge 5 → bist_end first high after edge 15; scan_en_o high exactly 4 cycles total; busy high 9 cycles.
3. Seed 0001, taps 1100, busy → pat_o sequence 0001, 0010, 0100, 1001, 0011, 0110 from INIT onward; idle → pat_o = func_in (e.g. 1010).
4. resp_i=0, scan_out_i=0, SIGNATURE_VALID=0 → signature_o=0, pass_fail=1 in DONE; SIGNATURE_VALID=16'h0001 → pass_fail=0.
5. Reset asserted mid-RUN → IDLE next cycle, signature_o=0. bist_start during busy → no restart; the completion cycle is unchanged.
6. BIST_ABORT_EN defined: abort in SHIFT_OUT → IDLE, bist_end stays 0. Re-start → identical signature to an uninterrupted run.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST engine: FSM state encoding, default
// tap masks and the generic Fibonacci LFSR step used by bist_engine.
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        SHIFT_IN,
        RUN,
        SHIFT_OUT,
        DONE
    } state_t;

    // Widest LFSR that lfsr_next can step; narrower callers zero-extend.
    localparam int LFSR_MAX_BITS = 32;

    localparam logic [3:0]  TAPS_4  = 4'b1100;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    // Shift left and feed the parity of the tapped bits into bit 0; the caller
    // truncates the result back to its own width.
    function automatic logic [LFSR_MAX_BITS-1:0] lfsr_next(
        input logic [LFSR_MAX_BITS-1:0] state,
        input logic [LFSR_MAX_BITS-1:0] taps
    );
        return {state[LFSR_MAX_BITS-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: Fibonacci feedback over MISR_TAPS with the
// parallel input vector folded in on every enabled cycle.
module bist_misr
    import bist_pkg::*;
#(
    parameter int                   MISR_BITS = 16,
    parameter logic [MISR_BITS-1:0] MISR_TAPS = TAPS_16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [MISR_BITS-1:0] v,
    output logic [MISR_BITS-1:0] signature
);

    logic [MISR_BITS-1:0] sig;

    // NOTE: sequential state is written only with <= so every register sees the
    // pre-edge values of its neighbours, exactly as the flops do in silicon.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            sig <= '0;
        end else if (enable) begin
            sig <= {sig[MISR_BITS-2:0], ^(sig & MISR_TAPS)} ^ v;
        end
    end

    assign signature = sig;

endmodule

// File: rtl/bist_engine.sv
// Self-contained BIST engine: LFSR stimulus, scan-in/run/scan-out sequencing and
// MISR compaction with golden-signature compare. Define BIST_ABORT_EN for abort.
module bist_engine
    import bist_pkg::*;
#(
    parameter int                   PAT_BITS        = 4,
    parameter int                   RESP_BITS       = 4,
    parameter int                   MISR_BITS       = 16,
    parameter logic [PAT_BITS-1:0]  LFSR_TAPS       = TAPS_4,
    parameter logic [PAT_BITS-1:0]  LFSR_SEED       = 4'b0001,
    parameter logic [MISR_BITS-1:0] MISR_TAPS       = TAPS_16,
    parameter int                   SCAN_LEN        = 8,
    parameter int                   PAT_COUNT       = 255,
    parameter logic [MISR_BITS-1:0] SIGNATURE_VALID = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bist_start,
`ifdef BIST_ABORT_EN
    input  logic                 bist_abort,
`endif
    input  logic [PAT_BITS-1:0]  func_in,
    output logic [PAT_BITS-1:0]  pat_o,
    output logic                 cut_reset_o,
    output logic                 scan_en_o,
    output logic                 scan_in_o,
    input  logic                 scan_out_i,
    input  logic [RESP_BITS-1:0] resp_i,
    output logic                 bist_busy,
    output logic                 bist_end,
    output logic                 pass_fail,
    output logic [MISR_BITS-1:0] signature_o
);

    localparam int CNT_MAX = (SCAN_LEN > PAT_COUNT) ? SCAN_LEN : PAT_COUNT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]    SCAN_LAST = CNT_W'(SCAN_LEN - 1);
    localparam logic [CNT_W-1:0]    RUN_LAST  = CNT_W'(PAT_COUNT - 1);
    // An all-zero seed would lock the LFSR, so it is forced to 1.
    localparam logic [PAT_BITS-1:0] SEED      = (LFSR_SEED == '0) ? PAT_BITS'(1) : LFSR_SEED;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [PAT_BITS-1:0]  lfsr;
    logic                 start_q;
    logic                 busy;
    logic                 advance;
    logic                 last;
    logic                 abort_hit;
    logic                 misr_clear;
    logic                 misr_enable;
    logic [MISR_BITS-1:0] misr_v;

    assign busy    = (state == INIT) || advance;
    assign advance = (state == SHIFT_IN) || (state == RUN) || (state == SHIFT_OUT);

`ifdef BIST_ABORT_EN
    assign abort_hit = bist_abort && busy;
`else
    assign abort_hit = 1'b0;
`endif

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        last = 1'b0;
        case (state)
            SHIFT_IN, SHIFT_OUT: last = (cnt == SCAN_LAST);
            RUN:                 last = (cnt == RUN_LAST);
            default:             last = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_q) state_nxt = INIT;
            INIT:      state_nxt = SHIFT_IN;
            SHIFT_IN:  if (last) state_nxt = RUN;
            RUN:       if (last) state_nxt = SHIFT_OUT;
            SHIFT_OUT: if (last) state_nxt = DONE;
            DONE:      if (start_q) state_nxt = INIT;
            default:   state_nxt = IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = IDLE;
        end
    end

    // The start request is registered, so a run begins two edges after the
    // request is first sampled; while busy the FSM never looks at it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            lfsr    <= SEED;
            start_q <= 1'b0;
        end else begin
            start_q <= bist_start;
            state   <= state_nxt;

            if (state_nxt != state) begin
                cnt <= '0;
            end else if (advance) begin
                cnt <= cnt + 1'b1;
            end

            if (abort_hit || (state == INIT)) begin
                lfsr <= SEED;
            end else if (advance) begin
                lfsr <= PAT_BITS'(lfsr_next(LFSR_MAX_BITS'(lfsr), LFSR_MAX_BITS'(LFSR_TAPS)));
            end
        end
    end

    assign misr_clear  = (state == INIT) || abort_hit;
    assign misr_enable = advance;
    assign misr_v      = MISR_BITS'({scan_out_i, resp_i});

    bist_misr #(
        .MISR_BITS (MISR_BITS),
        .MISR_TAPS (MISR_TAPS)
    ) u_misr (
        .clock     (clock),
        .reset     (reset),
        .clear     (misr_clear),
        .enable    (misr_enable),
        .v         (misr_v),
        .signature (signature_o)
    );

    assign pat_o       = busy ? lfsr : func_in;
    assign scan_in_o   = lfsr[PAT_BITS-1];
    assign scan_en_o   = (state == SHIFT_IN) || (state == SHIFT_OUT);
    assign cut_reset_o = reset || (state == INIT) || abort_hit;
    assign bist_busy   = busy;
    assign bist_end    = (state == DONE);
    assign pass_fail   = bist_end && (signature_o == SIGNATURE_VALID);

endmodule

// File: tb/tb_bist_engine.sv
// Scoreboard bench for bist_engine: random CUT responses, reference signature
// and pattern sequence computed arithmetically, checked by a separate monitor.
module tb_bist_engine;

    localparam int         SL    = 2;
    localparam int         PC    = 4;
    localparam int         N     = 2 * SL + PC;
    localparam logic [3:0] SEED  = 4'b0001;
    localparam logic [3:0] TAPS  = 4'b1100;
    localparam int         MTAPS = 'hB400;

    logic        clock = 1'b0;
    logic        reset;
    logic        bist_start;
    logic [3:0]  func_in;
    logic        scan_out_i;
    logic [3:0]  resp_i;
`ifdef BIST_ABORT_EN
    logic        bist_abort;
`endif

    logic [3:0]  pat_o, pat_o_b;
    logic        cut_reset_o, cut_reset_o_b;
    logic        scan_en_o, scan_en_o_b;
    logic        scan_in_o, scan_in_o_b;
    logic        bist_busy, bist_busy_b;
    logic        bist_end, bist_end_b;
    logic        pass_fail, pass_fail_b;
    logic [15:0] signature_o, signature_o_b;

    bist_engine #(
        .SCAN_LEN (SL), .PAT_COUNT (PC), .SIGNATURE_VALID (16'h0000)
    ) dut (
        .clock (clock), .reset (reset), .bist_start (bist_start),
`ifdef BIST_ABORT_EN
        .bist_abort (bist_abort),
`endif
        .func_in (func_in), .pat_o (pat_o), .cut_reset_o (cut_reset_o),
        .scan_en_o (scan_en_o), .scan_in_o (scan_in_o), .scan_out_i (scan_out_i),
        .resp_i (resp_i), .bist_busy (bist_busy), .bist_end (bist_end),
        .pass_fail (pass_fail), .signature_o (signature_o)
    );

    bist_engine #(
        .SCAN_LEN (SL), .PAT_COUNT (PC), .SIGNATURE_VALID (16'h0001)
    ) dut_b (
        .clock (clock), .reset (reset), .bist_start (bist_start),
`ifdef BIST_ABORT_EN
        .bist_abort (bist_abort),
`endif
        .func_in (func_in), .pat_o (pat_o_b), .cut_reset_o (cut_reset_o_b),
        .scan_en_o (scan_en_o_b), .scan_in_o (scan_in_o_b), .scan_out_i (scan_out_i),
        .resp_i (resp_i), .bist_busy (bist_busy_b), .bist_end (bist_end_b),
        .pass_fail (pass_fail_b), .signature_o (signature_o_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        int sig;
        int done_edge;
    } exp_t;

    exp_t       q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         edge_cnt = 0;
    logic [4:0] vlist[N];
    int         seq[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic int lfsr_step(input int x);
        int fb;
        fb = $countones(x & int'(TAPS)) % 2;
        return (x * 2 + fb) % 16;
    endfunction

    function automatic int misr_sig();
        int s;
        int fb;
        s = 0;
        for (int i = 0; i < N; i++) begin
            fb = $countones(s & MTAPS) % 2;
            s  = ((s * 2) % 65536 + fb) ^ int'(vlist[i]);
        end
        return s;
    endfunction

    // ---------------- monitor ----------------
    int  bi = 0, nb = 0, sen = 0, last_sig = 0;
    bit  prev_busy = 0, prev_end = 0;
    exp_t e;

    always @(posedge clock) begin
        edge_cnt++;
        #1;
        if (reset) begin
            prev_busy = 0;
            prev_end  = 0;
        end else begin
            if (bist_busy) begin
                if (!prev_busy) begin
                    bi = 0; nb = 0; sen = 0;
                end
                nb++;
                if (scan_en_o) sen++;
                check("cut_reset_busy", 32'(cut_reset_o), 32'(bi == 0));
                if (bi >= 1 && bi <= N) begin
                    check("pat_seq", 32'(pat_o), 32'(seq[bi-1]));
                    check("scan_in", 32'(scan_in_o), 32'((seq[bi-1] >> 3) & 1));
                end
                bi++;
            end else begin
                check("pat_func", 32'(pat_o), 32'(func_in));
                check("scan_en_idle", 32'(scan_en_o), 0);
                if (bist_end && !prev_end) begin
                    check("sb_nonempty", 32'(q.size() != 0), 1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        last_sig = e.sig;
                        check("done_edge", 32'(edge_cnt), 32'(e.done_edge));
                        check("signature", 32'(signature_o), 32'(e.sig));
                        check("pass_fail_0", 32'(pass_fail), 32'(e.sig == 0));
                        check("pass_fail_1", 32'(pass_fail_b), 32'(e.sig == 1));
                        check("busy_cycles", 32'(nb), 32'(N + 1));
                        check("scan_en_cycles", 32'(sen), 32'(2 * SL));
                    end
                end else if (bist_end && prev_end) begin
                    check("sig_hold", 32'(signature_o), 32'(last_sig));
                end
            end
            prev_busy = bist_busy;
            prev_end  = bist_end;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clock);
        func_in = 4'($urandom_range(0, 15));
    endtask

    // Launch one run; mid>0 re-pulses start while busy, cut_j>0 interrupts the
    // run at edge k+cut_j with reset (or abort) and no expectation is queued.
    task automatic launch(input bit zero, input bit reuse, input int mid,
                          input int cut_j, input bit by_abort);
        int k;
        if (!reuse) begin
            for (int i = 0; i < N; i++) vlist[i] = zero ? 5'd0 : 5'($urandom_range(0, 31));
        end
        tick();
        bist_start = 1'b1;
        k = edge_cnt + 1;
        for (int j = 1; j <= 2 + N; j++) begin
            tick();
            bist_start = (j == mid);
            if (j >= 3) {scan_out_i, resp_i} = vlist[j-3];
            else        {scan_out_i, resp_i} = zero ? 5'd0 : 5'($urandom_range(0, 31));
            if (j == cut_j) begin
                if (by_abort) begin
`ifdef BIST_ABORT_EN
                    bist_abort = 1'b1;
                    #1 check("abort_cut_reset", 32'(cut_reset_o), 1);
`endif
                end else begin
                    reset = 1'b1;
                end
                @(posedge clock);
                #1;
                check("cut_busy", 32'(bist_busy), 0);
                check("cut_end", 32'(bist_end), 0);
                check("cut_sig", 32'(signature_o), 0);
                if (!by_abort) check("cut_reset_hold", 32'(cut_reset_o), 1);
                tick();
                reset = 1'b0;
`ifdef BIST_ABORT_EN
                bist_abort = 1'b0;
`endif
                return;
            end
        end
        q.push_back('{sig: misr_sig(), done_edge: k + 2 + N});
    endtask

    task automatic wait_done();
        for (int c = 0; c < 64; c++) begin
            if (bist_end) break;
            tick();
        end
        check("done_reached", 32'(bist_end), 1);
    endtask

    initial begin
        reset      = 1'b1;
        bist_start = 1'b1;
        func_in    = 4'b1010;
        resp_i     = '0;
        scan_out_i = 1'b0;
`ifdef BIST_ABORT_EN
        bist_abort = 1'b0;
`endif
        seq[0] = int'(SEED);
        for (int i = 1; i < N; i++) seq[i] = lfsr_step(seq[i-1]);

        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 32'(bist_busy), 0);
        check("rst_end", 32'(bist_end), 0);
        check("rst_sig", 32'(signature_o), 0);
        check("rst_cut_reset", 32'(cut_reset_o), 1);
        check("rst_scan_en", 32'(scan_en_o), 0);
        @(negedge clock);
        reset      = 1'b0;
        bist_start = 1'b0;

        // Zero responses: start sampled at edge 5, DONE after edge 15.
        launch(1'b1, 1'b0, 0, 0, 1'b0);
        wait_done();
        repeat (3) tick();

        // Random runs, half with a stray start pulse while busy.
        for (int r = 0; r < 6; r++) begin
            launch(1'b0, 1'b0, (r % 2 == 1) ? int'($urandom_range(2, N)) : 0, 0, 1'b0);
            wait_done();
            repeat ($urandom_range(1, 4)) tick();
        end

        // Reset during RUN, then a clean run from IDLE.
        launch(1'b0, 1'b0, 0, int'($urandom_range(SL + 3, SL + PC + 2)), 1'b0);
        repeat (3) tick();
        check("idle_after_reset", 32'(bist_busy), 0);
        launch(1'b0, 1'b0, 0, 0, 1'b0);
        wait_done();

`ifdef BIST_ABORT_EN
        // Abort in SHIFT_OUT, then rerun the same responses uninterrupted.
        repeat (2) tick();
        launch(1'b0, 1'b0, 0, int'($urandom_range(SL + PC + 3, N + 2)), 1'b1);
        repeat (2) tick();
        check("abort_end_low", 32'(bist_end), 0);
        launch(1'b0, 1'b1, 0, 0, 1'b0);
        wait_done();
        tick();
        bist_abort = 1'b1;
        @(posedge clock);
        #1;
        check("abort_ignored_done", 32'(bist_end), 1);
        tick();
        bist_abort = 1'b0;
`endif

        repeat (3) tick();
        check("sb_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
